// File: rtl/ttrng_sample_ctrl.sv
// Sequencer for the SR-latch entropy network: arm, race, settle, sample,
// byte packing on a valid/ready port, and a repetition-count health test.
module ttrng_sample_ctrl #(
    parameter int ARM_CYCLES    = 2,
    parameter int SETTLE_CYCLES = 4,
    parameter int REP_LIMIT     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       raw_bit,
    output logic       latch_s,
    output logic       latch_r,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       health_fail
);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_ARM, S_SETTLE, S_SAMPLE, S_PRESENT, S_FAULT
    } state_t;

    localparam logic [7:0] ARM_LAST    = 8'(ARM_CYCLES - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] REP_MAX     = 8'(REP_LIMIT);

    state_t     r_state;
    state_t     w_state_n;
    logic [7:0] r_cnt;
    logic [3:0] r_bit_cnt;
    logic [6:0] r_shift;
    logic [7:0] r_data;
    logic [7:0] r_rep;
    logic       r_last;
    logic       r_sync1;
    logic       r_sync2;
    logic       r_valid;
    logic [7:0] w_rep_n;
    logic       w_byte_done;

    // r_rep==0 marks "no sample since reset"
    always_comb begin
        w_rep_n = 8'd1;
        if (r_rep != 8'd0 && r_sync2 == r_last)
            w_rep_n = r_rep + 8'd1;
    end

    assign w_byte_done = (r_bit_cnt == 4'd7);

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= S_INIT;
        else
            r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            S_INIT:
                if (r_cnt == ARM_LAST) w_state_n = S_IDLE;
            S_IDLE:
                if (ena) w_state_n = S_ARM;
            S_ARM:
                if (!ena)                   w_state_n = S_IDLE;
                else if (r_cnt == ARM_LAST) w_state_n = S_SETTLE;
            S_SETTLE:
                if (!ena)                      w_state_n = S_IDLE;
                else if (r_cnt == SETTLE_LAST) w_state_n = S_SAMPLE;
            S_SAMPLE:
                if (!ena)                    w_state_n = S_IDLE;
                else if (w_rep_n == REP_MAX) w_state_n = S_FAULT;
                else if (w_byte_done)        w_state_n = S_PRESENT;
                else                         w_state_n = S_ARM;
            S_PRESENT:
                if (!ena)           w_state_n = S_IDLE;
                else if (out_ready) w_state_n = S_ARM;
            S_FAULT:
                w_state_n = S_FAULT;
            default:
                w_state_n = S_INIT;
        endcase
    end

    always_comb begin
        latch_s     = (r_state == S_ARM);
        latch_r     = !(r_state == S_SETTLE || r_state == S_SAMPLE);
        busy        = (r_state == S_ARM) || (r_state == S_SETTLE) ||
                      (r_state == S_SAMPLE) || (r_state == S_PRESENT);
        health_fail = (r_state == S_FAULT);
        out_valid   = r_valid;
        out_data    = r_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_cnt     <= 8'd0;
            r_bit_cnt <= 4'd0;
            r_shift   <= 7'd0;
            r_data    <= 8'd0;
            r_rep     <= 8'd0;
            r_last    <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            r_sync1 <= raw_bit;
            r_sync2 <= r_sync1;
            r_cnt   <= (w_state_n != r_state) ? 8'd0 : r_cnt + 8'd1;
            r_valid <= (w_state_n == S_PRESENT);
            if (r_state == S_SAMPLE && ena) begin
                r_shift   <= {r_shift[5:0], r_sync2};
                r_bit_cnt <= r_bit_cnt + 4'd1;
                r_rep     <= w_rep_n;
                r_last    <= r_sync2;
                if (w_state_n == S_PRESENT)
                    r_data <= {r_shift, r_sync2};
            end
            if (w_state_n == S_IDLE || r_state == S_PRESENT)
                r_bit_cnt <= 4'd0;
        end
    end

endmodule

// File: tb/tb_ttrng_sample_ctrl.sv
// Directed bench for ttrng_sample_ctrl with a queue scoreboard that
// checks every accepted byte against the expected value.
module tb_ttrng_sample_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       raw_bit;
    logic       latch_s;
    logic       latch_r;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       health_fail;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] q[$];

    ttrng_sample_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .raw_bit    (raw_bit),
        .latch_s    (latch_s),
        .latch_r    (latch_r),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .health_fail(health_fail)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted byte is popped and compared
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL xfer_unexpected: got %0h expected none",
                         out_data);
            end else begin
                logic [7:0] e;
                e = q.pop_front();
                chk("xfer_data", {24'd0, out_data}, {24'd0, e});
            end
        end
    end

    // Starts just before the first ARM edge; ends in cycle 56
    task automatic run_byte(input logic [7:0] b, input logic rdy,
                            input logic exp_valid, input string tag);
        for (int k = 0; k < 8; k++) begin
            raw_bit = b[7-k];
            for (int j = 0; j < 7; j++) begin
                step();
                if (k == 0 && j == 0) out_ready = rdy;
                if (k == 0) begin
                    chk({tag, "_s"}, {31'd0, latch_s}, (j < 2) ? 1 : 0);
                    chk({tag, "_r"}, {31'd0, latch_r}, (j < 2) ? 1 : 0);
                end
            end
        end
        chk({tag, "_valid_c55"}, {31'd0, out_valid}, 0);
        step();
        if (exp_valid) begin
            chk({tag, "_valid_c56"}, {31'd0, out_valid}, 1);
            chk({tag, "_data_c56"}, {24'd0, out_data}, {24'd0, b});
            chk({tag, "_busy"}, {31'd0, busy}, 1);
        end else begin
            chk({tag, "_hfail"}, {31'd0, health_fail}, 1);
            chk({tag, "_novalid"}, {31'd0, out_valid}, 0);
            chk({tag, "_fs"}, {31'd0, latch_s}, 0);
            chk({tag, "_fr"}, {31'd0, latch_r}, 1);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        ena       = 1'b0;
        raw_bit   = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        chk("rst_s", {31'd0, latch_s}, 0);
        chk("rst_r", {31'd0, latch_r}, 1);
        chk("rst_valid", {31'd0, out_valid}, 0);
        chk("rst_hfail", {31'd0, health_fail}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_data", {24'd0, out_data}, 0);

        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("init_s", {31'd0, latch_s}, 0);
            chk("init_r", {31'd0, latch_r}, 1);
            chk("init_busy", {31'd0, busy}, 0);
        end

        // Byte assembly with immediate acceptance
        ena = 1'b1;
        q.push_back(8'hB2);
        run_byte(8'hB2, 1'b1, 1'b1, "b2");

        // Next byte held under backpressure
        q.push_back(8'h4D);
        run_byte(8'h4D, 1'b0, 1'b1, "bp");
        for (int i = 0; i < 20; i++) begin
            step();
            chk("bp_valid", {31'd0, out_valid}, 1);
            chk("bp_data", {24'd0, out_data}, 32'h4D);
            chk("bp_noarm", {31'd0, latch_s}, 0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_arm_next", {31'd0, latch_s}, 1);
        chk("bp_valid_drop", {31'd0, out_valid}, 0);
        ena = 1'b0;
        step();
        chk("idle_busy", {31'd0, busy}, 0);

        // Abort during SETTLE of bit 5
        ena = 1'b1;
        for (int t = 0; t < 38; t++) begin
            raw_bit = t[0];
            step();
        end
        chk("ab_settle_s", {31'd0, latch_s}, 0);
        chk("ab_settle_r", {31'd0, latch_r}, 0);
        ena = 1'b0;
        step();
        chk("ab_s", {31'd0, latch_s}, 0);
        chk("ab_r", {31'd0, latch_r}, 1);
        chk("ab_busy", {31'd0, busy}, 0);
        chk("ab_valid", {31'd0, out_valid}, 0);
        ena = 1'b1;
        q.push_back(8'h69);
        run_byte(8'h69, 1'b1, 1'b1, "fresh");

        // Stuck-at-0 source: first byte passes, 16th sample faults
        q.push_back(8'h00);
        run_byte(8'h00, 1'b1, 1'b1, "z1");
        run_byte(8'h00, 1'b1, 1'b0, "z2");
        for (int i = 0; i < 6; i++) begin
            ena = i[0];
            step();
            chk("flt_hfail", {31'd0, health_fail}, 1);
            chk("flt_valid", {31'd0, out_valid}, 0);
            chk("flt_busy", {31'd0, busy}, 0);
            chk("flt_s", {31'd0, latch_s}, 0);
            chk("flt_r", {31'd0, latch_r}, 1);
        end

        rst_n = 1'b0;
        step();
        chk("frst_hfail", {31'd0, health_fail}, 0);
        chk("frst_r", {31'd0, latch_r}, 1);

        // INIT must hold off ARM even with ena already high
        rst_n = 1'b1;
        ena   = 1'b1;
        step();
        chk("init2_s", {31'd0, latch_s}, 0);
        step();
        chk("init2_s", {31'd0, latch_s}, 0);
        run_byte(8'hC3, 1'b0, 1'b1, "c3");

        // Reset while presenting
        rst_n = 1'b0;
        step();
        chk("prst_valid", {31'd0, out_valid}, 0);
        chk("prst_data", {24'd0, out_data}, 0);
        chk("prst_busy", {31'd0, busy}, 0);
        chk("prst_s", {31'd0, latch_s}, 0);
        chk("prst_r", {31'd0, latch_r}, 1);
        rst_n = 1'b1;
        ena   = 1'b0;
        step();
        step();

        chk("q_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
